matvec_vector_feeder: RTL
=========================

Name: matvec_vector_feeder

Overview:
- Sits between two chained matvec_multiplier instances (layer N -> layer N+1).
- Captures layer N's serial result_out/result_valid stream into an internal buffer.
- Replays the buffer as BANDWIDTH-wide chunks on layer N+1's vector-write interface, then pulses its start and waits for it to finish.
- It is the transmitting end of the vector_write_enable / vector_base_addr / vector_in protocol.

Parameters:
MAX_LEN, 64, buffer depth in words; max vector length; multiple of BANDWIDTH
BANDWIDTH, 4, words per vector chunk; must match downstream matvec_multiplier
DATA_WIDTH, 16, word width (signed Q4.12)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
res_in  input  DATA_WIDTH  signed result word from upstream result_out
res_valid  input  1  upstream result_valid; one word captured per high cycle
send  input  1  single-cycle request to transmit the buffer
vector_write_enable  output  1  chunk-valid strobe to downstream
vector_base_addr  output  $clog2(MAX_LEN)  word index of chunk element 0
vector_in  output  BANDWIDTH x DATA_WIDTH  chunk payload (unpacked array)
mv_start  output  1  single-cycle start to downstream matvec
mv_busy  input  1  downstream busy
count  output  $clog2(MAX_LEN)+1  words currently buffered
busy  output  1  high in any state other than IDLE
done  output  1  single-cycle pulse when the downstream run completes
overflow  output  1  sticky; a word was dropped

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, count 0, overflow 0. Buffer contents don't-care. Asserting rst mid-SEND or mid-WAIT aborts immediately; no further strobes.
- All outputs are registered.
- Capture (IDLE only): on res_valid, buf[count] <= res_in and count++.
  - count==MAX_LEN: word dropped, overflow <= 1.
  - res_valid while busy: word dropped, overflow <= 1.
  - overflow clears only on reset.
- States: IDLE, SEND, START, WAIT_HI, WAIT_LO.
- IDLE:
  - send && count>0 -> SEND, chunk index k=0; latch nchunks = ceil(count/BANDWIDTH).
  - send && count==0 -> done pulses the next cycle; stay in IDLE.
  - send while busy -> ignored.
  - res_valid and send in the same IDLE cycle: the word is captured first and is included in the transmit.
- SEND: one chunk per cycle, back-to-back. vector_write_enable stays high continuously for nchunks cycles, starting the cycle after send.
  - Chunk k: vector_base_addr = k*BANDWIDTH.
  - vector_in[j] = buf[k*BANDWIDTH+j] if that index < count, else 0 (zero pad).
  - After the last chunk -> START.
- START: mv_start=1 for exactly one cycle, vector_write_enable=0 -> WAIT_HI.
- WAIT_HI: wait for mv_busy=1, then -> WAIT_LO. No timeout.
- WAIT_LO: wait for mv_busy=0. Then done=1 for one cycle, count <= 0, -> IDLE.
- Latency: send in cycle 0 -> first chunk in cycle 1 -> mv_start in cycle nchunks+1.
- vector_in and vector_base_addr are 0 whenever vector_write_enable=0.

Test Plan:
1. Capture 4 words 4096,8192,12288,16384; send; mv_busy modelled high 3 cycles after mv_start -> exactly one chunk: base 0, payload {4096,8192,12288,16384}; mv_start next cycle; done after mv_busy falls; count returns to 0.
2. Capture 6 words 1..6; send -> chunk base 0 {1,2,3,4}, then chunk base 4 {5,6,0,0} on consecutive cycles with enable held high; then mv_start.
3. send with count=0 -> done pulses one cycle later; vector_write_enable and mv_start never assert.
4. Capture 65 words with MAX_LEN=64 -> count=64, overflow=1; the 65th word is absent from the chunks. Also: res_valid during SEND -> overflow=1 and count unchanged.
5. Assert rst during the second chunk of an 8-word send -> all outputs 0 within the same cycle; no mv_start. A later capture and send of 4 words works normally.
6. Assert res_valid and send in the same cycle with count=3 -> 4 words are transmitted, payload 4th element = the new word.

Source files
------------

// File: rtl/matvec_vector_feeder.sv
// matvec_vector_feeder: buffers layer N results and replays them as
// BANDWIDTH-wide chunks into layer N+1, then starts it and waits for it.
module matvec_vector_feeder #(
  parameter int MAX_LEN    = 64,
  parameter int BANDWIDTH  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] res_in,
  input  logic                         res_valid,
  input  logic                         send,
  output logic                         vector_write_enable,
  output logic [$clog2(MAX_LEN)-1:0]   vector_base_addr,
  output logic signed [DATA_WIDTH-1:0] vector_in [BANDWIDTH],
  output logic                         mv_start,
  input  logic                         mv_busy,
  output logic [$clog2(MAX_LEN):0]     count,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    START,
    WAIT_HI,
    WAIT_LO
  } state_e;

  state_e state_q;

  logic signed [DATA_WIDTH-1:0] mem_q [MAX_LEN];
  logic signed [DATA_WIDTH-1:0] vin_q [BANDWIDTH];
  logic signed [DATA_WIDTH-1:0] vin_d [BANDWIDTH];

  logic [CW-1:0] count_q, cnt_d, nch_q, nch_d;
  logic [CW-1:0] k_q, ksel, idx;
  logic [AW-1:0] base_q, base_d;
  logic          vwe_q, start_q, busy_q, done_q, ovf_q;
  logic          cap;

  assign cap    = res_valid && (state_q == IDLE)
               && (count_q != CW'(MAX_LEN));
  assign cnt_d  = count_q + CW'(cap);
  assign nch_d  = (cnt_d + CW'(BANDWIDTH - 1))
                / CW'(BANDWIDTH);
  assign ksel   = (state_q == IDLE) ? '0 : k_q;
  assign base_d = AW'(ksel * CW'(BANDWIDTH));

  // The word captured in the send cycle is forwarded straight into chunk 0.
  always_comb begin
    idx = '0;
    for (int j = 0; j < BANDWIDTH; j++) begin
      idx      = ksel * CW'(BANDWIDTH) + CW'(j);
      vin_d[j] = '0;
      if (idx < cnt_d) begin
        vin_d[j] = (cap && idx == count_q)
                 ? res_in : mem_q[idx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem_q[count_q[AW-1:0]] <= res_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      nch_q   <= '0;
      k_q     <= '0;
      base_q  <= '0;
      vwe_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int j = 0; j < BANDWIDTH; j++) vin_q[j] <= '0;
    end else begin
      done_q <= 1'b0;
      if (res_valid && !cap) ovf_q <= 1'b1;
      if (cap) count_q <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (send && cnt_d != '0) begin
            state_q <= SEND;
            busy_q  <= 1'b1;
            vwe_q   <= 1'b1;
            base_q  <= base_d;
            vin_q   <= vin_d;
            k_q     <= CW'(1);
            nch_q   <= nch_d;
          end else if (send) begin
            done_q <= 1'b1;
          end
        end
        SEND: begin
          if (k_q == nch_q) begin
            state_q <= START;
            vwe_q   <= 1'b0;
            base_q  <= '0;
            start_q <= 1'b1;
            for (int j = 0; j < BANDWIDTH; j++) vin_q[j] <= '0;
          end else begin
            base_q <= base_d;
            vin_q  <= vin_d;
            k_q    <= k_q + CW'(1);
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (mv_busy) state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!mv_busy) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            count_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vector_write_enable = vwe_q;
  assign vector_base_addr    = base_q;
  assign vector_in           = vin_q;
  assign mv_start            = start_q;
  assign count               = count_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign overflow            = ovf_q;

endmodule
